mipi_rx_lane_aligner: RTL and testbench



---
 rtl/mipi_rx_pkg.sv | 20 ++
 rtl/mipi_rx_lane_aligner_if.sv | 24 ++
 rtl/mipi_lane_sync_search.sv | 81 ++++++++
 rtl/mipi_rx_lane_aligner.sv | 142 ++++++++++++++
 tb/tb_mipi_rx_lane_aligner.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the MIPI RX lane aligner: FSM states, sync byte, lane packing.
package mipi_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HUNT    = 2'd1,
      ALIGNED = 2'd2,
      ERROR   = 2'd3
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;
   localparam int         LANE_NUM          = 4;
   localparam int         LANE_W            = 8;

   // Lane 0 sits in the most significant byte of the 32-bit bus.
   function automatic int lane_lsb(input int lane);
      return (LANE_NUM - 1 - lane) * LANE_W;
   endfunction

endpackage

// File: rtl/mipi_rx_lane_aligner_if.sv
// Raw HS byte stream in, aligned word stream and status out; slave = aligner side, master = source/sink side.
interface mipi_rx_lane_aligner_if;
   import mipi_rx_pkg::*;

   logic                       I_hs_valid;
   logic [LANE_NUM*LANE_W-1:0] I_hs_data;
   logic                       O_valid;
   logic                       O_sot;
   logic [LANE_NUM*LANE_W-1:0] O_data;
   logic                       O_locked;
   logic                       O_sync_err;
   logic [15:0]                O_err_cnt;

   modport slave (
      input  I_hs_valid, I_hs_data,
      output O_valid, O_sot, O_data, O_locked, O_sync_err, O_err_cnt
   );

   modport master (
      output I_hs_valid, I_hs_data,
      input  O_valid, O_sot, O_data, O_locked, O_sync_err, O_err_cnt
   );

endinterface

// File: rtl/mipi_lane_sync_search.sv
// Per-lane SoT hunter: locks the bit offset of SYNC_BYTE and re-frames the lane bytes at that offset.
// Re-framed bytes feed a MAX_SKEW-deep delay line; i_tap selects the deskew delay (0 = no delay).
module mipi_lane_sync_search
   import mipi_rx_pkg::*;
#(
   parameter int         MAX_SKEW  = 3,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_vld,
   input  logic [7:0] i_dat,
   input  logic       i_srch,
   input  logic       i_clr,
   input  logic [2:0] i_tap,
   output logic       o_match,
   output logic       o_locked,
   output logic [7:0] o_dat
);

   logic [7:0]  r_prev;
   logic        r_lock;
   logic [2:0]  r_off;
   logic [7:0]  r_dl [MAX_SKEW];
   logic [15:0] w_win;
   logic        w_hit;
   logic [2:0]  w_k;
   logic [7:0]  w_byte;

   assign w_win    = {i_dat, r_prev};
   assign o_match  = i_srch & w_hit;
   assign o_locked = r_lock;

   // Descending scan: the lowest matching offset is the last one written and wins.
   always_comb begin
      w_hit = 1'b0;
      w_k   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w_win[k +: 8] == SYNC_BYTE) begin
            w_hit = 1'b1;
            w_k   = 3'(k);
         end
      end
   end

   always_comb begin
      w_byte = w_win[7:0];
      for (int k = 0; k < 8; k++) begin
         if (r_off == 3'(k)) w_byte = w_win[k +: 8];
      end
   end

   always_comb begin
      o_dat = w_byte;
      for (int d = 1; d <= MAX_SKEW; d++) begin
         if (i_tap == 3'(d)) o_dat = r_dl[d-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev <= 8'h00;
         r_lock <= 1'b0;
         r_off  <= 3'd0;
         for (int i = 0; i < MAX_SKEW; i++) r_dl[i] <= 8'h00;
      end else begin
         if (i_vld) begin
            r_prev   <= i_dat;
            r_dl[0]  <= w_byte;
            for (int i = 1; i < MAX_SKEW; i++) r_dl[i] <= r_dl[i-1];
         end
         if (i_clr) begin
            r_lock <= 1'b0;
         end else if (o_match) begin
            r_lock <= 1'b1;
            r_off  <= w_k;
         end
      end
   end

endmodule

// File: rtl/mipi_rx_lane_aligner.sv
// 4-lane D-PHY byte/lane aligner: first word 2 cycles after the last lane's sync match, then 1 word/cycle; no backpressure.
// MIPI_ALIGN_ERR_CNT_EN enables the saturating sync-error counter on O_err_cnt (otherwise tied to zero).
module mipi_rx_lane_aligner
   import mipi_rx_pkg::*;
#(
   parameter int         MAX_SKEW  = 3,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic                    I_clk,
   input  logic                    I_rst_n,
   mipi_rx_lane_aligner_if.slave   bus
);

   state_t                     r_st, w_st_nx;
   logic                       w_vld;
   logic [LANE_NUM-1:0]        w_match, w_lock, w_srch;
   logic [7:0]                 w_lane_dat [LANE_NUM];
   logic [2:0]                 r_dly      [LANE_NUM];
   logic [2:0]                 r_lk_sc    [LANE_NUM];
   logic [2:0]                 r_sc, w_s;
   logic                       r_run;
   logic                       w_all, w_ent, w_err;
   logic [LANE_NUM*LANE_W-1:0] w_word, r_dat;
   logic                       r_vld, r_sot, r_err, r_first;

   assign w_vld = bus.I_hs_valid;

   for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
      assign w_srch[g] = (r_st == HUNT) & w_vld & ~w_lock[g];
      assign w_word[lane_lsb(g) +: LANE_W] = w_lane_dat[g];

      mipi_lane_sync_search #(.MAX_SKEW(MAX_SKEW), .SYNC_BYTE(SYNC_BYTE)) u_lane (
         .i_clk    (I_clk),
         .i_rst_n  (I_rst_n),
         .i_vld    (w_vld),
         .i_dat    (bus.I_hs_data[lane_lsb(g) +: LANE_W]),
         .i_srch   (w_srch[g]),
         .i_clr    (~w_vld),
         .i_tap    (r_dly[g]),
         .o_match  (w_match[g]),
         .o_locked (w_lock[g]),
         .o_dat    (w_lane_dat[g])
      );
   end

   // w_s is the skew of the current cycle relative to the first lane lock.
   always_comb begin
      w_s      = r_run ? r_sc : 3'd0;
      w_all    = &(w_lock | w_match);
      w_st_nx  = r_st;
      w_ent    = 1'b0;
      w_err    = 1'b0;
      if (!w_vld) begin
         w_st_nx = IDLE;
      end else begin
         case (r_st)
            IDLE:    w_st_nx = HUNT;
            HUNT: begin
               if (w_all) begin
                  w_st_nx = ALIGNED;
                  w_ent   = 1'b1;
               end else if (r_run && w_s == 3'(MAX_SKEW)) begin
                  w_st_nx = ERROR;
                  w_err   = 1'b1;
               end
            end
            ALIGNED: w_st_nx = ALIGNED;
            ERROR:   w_st_nx = ERROR;
            default: w_st_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) r_st <= IDLE;
      else          r_st <= w_st_nx;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_run <= 1'b0;
         r_sc  <= 3'd0;
         for (int i = 0; i < LANE_NUM; i++) begin
            r_lk_sc[i] <= 3'd0;
            r_dly[i]   <= 3'd0;
         end
      end else begin
         if (r_st == HUNT && w_st_nx == HUNT && (r_run || |w_match)) begin
            r_run <= 1'b1;
            r_sc  <= w_s + 3'd1;
         end else if (w_st_nx != HUNT) begin
            r_run <= 1'b0;
            r_sc  <= 3'd0;
         end
         for (int i = 0; i < LANE_NUM; i++) begin
            if (w_match[i]) r_lk_sc[i] <= w_s;
            if (w_ent)      r_dly[i]   <= w_match[i] ? 3'd0 : (w_s - r_lk_sc[i]);
         end
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_vld   <= 1'b0;
         r_sot   <= 1'b0;
         r_dat   <= '0;
         r_err   <= 1'b0;
         r_first <= 1'b0;
      end else begin
         r_first <= w_ent;
         r_err   <= w_err;
         if (w_vld && r_st == ALIGNED) begin
            r_vld <= 1'b1;
            r_sot <= r_first;
            r_dat <= w_word;
         end else begin
            r_vld <= 1'b0;
            r_sot <= 1'b0;
         end
      end
   end

`ifdef MIPI_ALIGN_ERR_CNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n)                          r_err_cnt <= 16'h0000;
      else if (r_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
   end

   assign bus.O_err_cnt = r_err_cnt;
`else
   assign bus.O_err_cnt = 16'h0000;
`endif

   assign bus.O_valid    = r_vld;
   assign bus.O_sot      = r_sot;
   assign bus.O_data     = r_dat;
   assign bus.O_sync_err = r_err;
   assign bus.O_locked   = (r_st == ALIGNED);

endmodule

// File: tb/tb_mipi_rx_lane_aligner.sv
// Bench for mipi_rx_lane_aligner: lane bit streams built from sync position and payload, expected outputs derived from lane match cycles.
module tb_mipi_rx_lane_aligner;
   import mipi_rx_pkg::*;

   localparam int MAX_SKEW = 3;
   localparam int PAYN     = 64;
   localparam int EXPN     = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mipi_rx_lane_aligner_if bus();

   mipi_rx_lane_aligner #(.MAX_SKEW(MAX_SKEW), .SYNC_BYTE(8'hB8)) dut (
      .I_clk   (clk),
      .I_rst_n (rst_n),
      .bus     (bus)
   );

   int         n_chk   = 0;
   int         n_fail  = 0;
   int         exp_cnt = 0;
   logic [7:0] sync_v  = 8'hB8;
   int         z_arr [4];
   logic [7:0] pay   [4][PAYN];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Lane stream: z zero bits, then the sync byte, then payload bytes, all LSB-first.
   function automatic logic lane_bit(input int l, input int b);
      int z;
      int r;
      z = z_arr[l];
      if (z < 0 || b < z) return 1'b0;
      if (b < z + 8)      return sync_v[b - z];
      r = b - z - 8;
      if (r / 8 >= PAYN)  return 1'b0;
      return pay[l][r / 8][r % 8];
   endfunction

   function automatic logic [31:0] in_word(input int c);
      logic [31:0] w;
      w = '0;
      for (int l = 0; l < 4; l++)
         for (int bi = 0; bi < 8; bi++)
            w[(3 - l) * 8 + bi] = lane_bit(l, 8 * c + bi);
      return w;
   endfunction

   task automatic fill_pay(input bit directed);
      for (int l = 0; l < 4; l++)
         for (int j = 0; j < PAYN; j++)
            pay[l][j] = directed ? 8'((j + 1) * 17) : 8'($urandom);
   endtask

   task automatic chk_cnt();
`ifdef MIPI_ALIGN_ERR_CNT_EN
      chk("err_cnt", {16'h0, bus.O_err_cnt}, 32'(exp_cnt));
`else
      chk("err_cnt", {16'h0, bus.O_err_cnt}, 32'h0);
`endif
   endtask

   task automatic run_burst(input int len, input int rst_cyc);
      logic        e_vld [EXPN];
      logic        e_sot [EXPN];
      logic        e_lck [EXPN];
      logic        e_err [EXPN];
      logic [31:0] e_dat [EXPN];
      int  m, f, t;
      bit  all_s, any_s, err_ev;
      f = 1000; t = -1; all_s = 1'b1; any_s = 1'b0; err_ev = 1'b0;
      for (int l = 0; l < 4; l++) begin
         if (z_arr[l] < 0) all_s = 1'b0;
         else begin
            m     = z_arr[l] / 8 + 1;
            any_s = 1'b1;
            if (m < f) f = m;
            if (m > t) t = m;
         end
      end
      for (int c = 0; c < EXPN; c++) begin
         e_vld[c] = 0; e_sot[c] = 0; e_lck[c] = 0; e_err[c] = 0; e_dat[c] = '0;
      end
      if (all_s && (t - f <= MAX_SKEW) && (t <= len - 1)) begin
         for (int c = t + 1; c <= len; c++) e_lck[c] = 1'b1;
         for (int c = t + 2; c <= len; c++) begin
            e_vld[c] = 1'b1;
            e_dat[c] = {pay[0][c-t-2], pay[1][c-t-2], pay[2][c-t-2], pay[3][c-t-2]};
         end
         if (t + 2 <= len) e_sot[t + 2] = 1'b1;
      end else if (any_s && (f + MAX_SKEW <= len - 1)) begin
         e_err[f + MAX_SKEW + 1] = 1'b1;
         err_ev = 1'b1;
      end

      for (int c = 0; c < len + 4; c++) begin
         @(posedge clk);
         #1;
         bus.I_hs_valid = (c < len);
         bus.I_hs_data  = (c < len) ? in_word(c) : $urandom;
         @(negedge clk);
         chk($sformatf("valid c%0d", c),    {31'h0, bus.O_valid},    {31'h0, e_vld[c]});
         chk($sformatf("sot c%0d", c),      {31'h0, bus.O_sot},      {31'h0, e_sot[c]});
         chk($sformatf("locked c%0d", c),   {31'h0, bus.O_locked},   {31'h0, e_lck[c]});
         chk($sformatf("sync_err c%0d", c), {31'h0, bus.O_sync_err}, {31'h0, e_err[c]});
         if (e_vld[c]) chk($sformatf("data c%0d", c), bus.O_data, e_dat[c]);
         if (c == rst_cyc) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst valid",  {31'h0, bus.O_valid},  32'h0);
            chk("rst sot",    {31'h0, bus.O_sot},    32'h0);
            chk("rst locked", {31'h0, bus.O_locked}, 32'h0);
            chk("rst data",   bus.O_data,            32'h0);
            exp_cnt = 0;
            chk_cnt();
            bus.I_hs_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            return;
         end
      end
      if (err_ev) exp_cnt++;
      chk_cnt();
   endtask

   initial begin
      int pre, maxm, len;
      rst_n          = 1'b0;
      bus.I_hs_valid = 1'b0;
      bus.I_hs_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset valid",    {31'h0, bus.O_valid},    32'h0);
      chk("reset sot",      {31'h0, bus.O_sot},      32'h0);
      chk("reset locked",   {31'h0, bus.O_locked},   32'h0);
      chk("reset sync_err", {31'h0, bus.O_sync_err}, 32'h0);
      chk("reset data",     bus.O_data,              32'h0);
      chk_cnt();
      @(negedge clk);
      rst_n = 1'b1;

      fill_pay(1'b1);
      z_arr = '{0, 0, 0, 0};    run_burst(8, -1);   // zero skew, k=0
      z_arr = '{8, 8, 13, 8};   run_burst(10, -1);  // lane2 offset 5
      z_arr = '{8, 8, 8, 24};   run_burst(10, -1);  // lane3 two cycles late
      z_arr = '{8, -1, 8, 8};   run_burst(10, -1);  // lane1 never syncs
      z_arr = '{0, 0, 0, 0};    run_burst(5, -1);   // short burst, then restart
      z_arr = '{3, 0, 7, 1};    run_burst(9, -1);
      z_arr = '{8, 8, 8, 40};   run_burst(12, -1);  // skew 4 > MAX_SKEW
      z_arr = '{0, 0, 0, 0};    run_burst(10, 5);   // reset while aligned
      z_arr = '{8, 11, 14, 31}; run_burst(10, -1);

      for (int it = 0; it < 40; it++) begin
         fill_pay(1'b0);
         pre  = $urandom_range(0, 2);
         maxm = 1;
         for (int l = 0; l < 4; l++) begin
            if ($urandom_range(0, 9) == 0) z_arr[l] = -1;
            else begin
               z_arr[l] = 8 * (pre + $urandom_range(0, MAX_SKEW + 1)) + $urandom_range(0, 7);
               if (z_arr[l] / 8 + 1 > maxm) maxm = z_arr[l] / 8 + 1;
            end
         end
         len = maxm + 1 + $urandom_range(0, 10);
         run_burst(len, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
